// File: rtl/sleep_unit_multi.sv
// Multi-core APB sleep controller: one RUN/SHUTDOWN/SLEEP FSM per core gating fetch and clock,
// with atomic CTRL set/clear, a per-core wake-up timer, and a wake-cause record.
module sleep_unit_multi #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NB_CORES       = 4,
  parameter int TMR_WIDTH      = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NB_CORES-1:0]       signal_i,
  input  logic [NB_CORES-1:0]       core_busy_i,
  output logic [NB_CORES-1:0]       fetch_en_o,
  output logic [NB_CORES-1:0]       clk_gate_core_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SHUTDOWN = 2'd1;
  localparam logic [1:0] ST_SLEEP    = 2'd2;

  localparam logic [2:0] W_CTRL       = 3'd0;
  localparam logic [2:0] W_STATUS     = 3'd1;
  localparam logic [2:0] W_TIMEOUT    = 3'd2;
  localparam logic [2:0] W_CTRL_SET   = 3'd3;
  localparam logic [2:0] W_CTRL_CLR   = 3'd4;
  localparam logic [2:0] W_WAKE_CAUSE = 3'd5;

  logic [NB_CORES-1:0]  ctrl_reg, ctrl_next;
  logic [NB_CORES-1:0]  wake_cause_reg, wake_cause_next;
  logic [TMR_WIDTH-1:0] timeout_reg;

  logic [NB_CORES-1:0] in_sleep;
  logic [NB_CORES-1:0] tmr_exp;
  logic [NB_CORES-1:0] wake_evt;

  logic       access;
  logic [2:0] word;
  logic       high_addr;
  logic       unmapped;
  logic       bad;
  logic       wr_ok;
  logic [31:0] rdata;

  assign PREADY = 1'b1;
  assign access = PSEL & PENABLE;
  assign word   = PADDR[4:2];

  if (APB_ADDR_WIDTH > 5) begin : g_high
    assign high_addr = |PADDR[APB_ADDR_WIDTH-1:5];
  end else begin : g_nohigh
    assign high_addr = 1'b0;
  end

  // Offsets 0x18 and up are unmapped; STATUS is the only read-only mapped word.
  assign unmapped = high_addr | (word >= 3'd6);
  assign bad      = unmapped | (PWRITE & (word == W_STATUS));
  assign PSLVERR  = access & bad;
  assign wr_ok    = access & PWRITE & ~bad;

  // Byte-lane bits and write data above the register widths carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  always_comb begin
    rdata = 32'd0;
    case (word)
      W_CTRL:       rdata[NB_CORES-1:0]  = ctrl_reg;
      W_STATUS:     rdata[NB_CORES-1:0]  = in_sleep;
      W_TIMEOUT:    rdata[TMR_WIDTH-1:0] = timeout_reg;
      W_WAKE_CAUSE: rdata[NB_CORES-1:0]  = wake_cause_reg;
      default:      rdata = 32'd0;
    endcase
  end

  assign PRDATA = (access && !unmapped) ? rdata : 32'd0;

  // Hardware clear of sleeping cores first, then the APB write so software wins.
  always_comb begin
    ctrl_next = ctrl_reg & ~in_sleep;
    if (wr_ok && word == W_CTRL) begin
      ctrl_next = PWDATA[NB_CORES-1:0];
    end else if (wr_ok && word == W_CTRL_SET) begin
      ctrl_next = ctrl_next | PWDATA[NB_CORES-1:0];
    end else if (wr_ok && word == W_CTRL_CLR) begin
      ctrl_next = ctrl_next & ~PWDATA[NB_CORES-1:0];
    end
  end

  // W1C first, hardware record last so a wake event beats a same-cycle clear.
  always_comb begin
    wake_cause_next = wake_cause_reg;
    if (wr_ok && word == W_WAKE_CAUSE) begin
      wake_cause_next = wake_cause_reg & ~PWDATA[NB_CORES-1:0];
    end
    wake_cause_next = (wake_cause_next & ~wake_evt) | (wake_evt & tmr_exp & ~signal_i);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_reg       <= '0;
      wake_cause_reg <= '0;
      timeout_reg    <= '0;
    end else begin
      ctrl_reg       <= ctrl_next;
      wake_cause_reg <= wake_cause_next;
      if (wr_ok && word == W_TIMEOUT) begin
        timeout_reg <= PWDATA[TMR_WIDTH-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
    logic [1:0]           state_reg, state_next;
    logic [TMR_WIDTH-1:0] cnt_reg;
    logic                 tmr_en_reg;
    logic                 en, sig, wake, enter_sleep;
    logic                 fetch_l, gate_l;

    assign en           = ctrl_reg[gi];
    assign sig          = signal_i[gi];
    assign in_sleep[gi] = (state_reg == ST_SLEEP);
    assign tmr_exp[gi]  = in_sleep[gi] & tmr_en_reg & (cnt_reg == '0);
    assign wake         = sig | tmr_exp[gi];
    assign wake_evt[gi] = in_sleep[gi] & wake;
    assign enter_sleep  = (state_reg == ST_SHUTDOWN) & ~sig & ~core_busy_i[gi];

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        ST_RUN:      if (en && !sig) state_next = ST_SHUTDOWN;
        ST_SHUTDOWN: begin
          if (sig)               state_next = ST_RUN;
          else if (!core_busy_i[gi]) state_next = ST_SLEEP;
        end
        ST_SLEEP:    if (wake) state_next = ST_RUN;
        default:     state_next = ST_RUN;
      endcase
    end

    always_comb begin
      fetch_l = 1'b1;
      gate_l  = 1'b1;
      case (state_reg)
        ST_RUN:      fetch_l = ~(en & ~sig);
        ST_SHUTDOWN: fetch_l = 1'b0;
        ST_SLEEP:    gate_l  = wake;
        default: begin
          fetch_l = 1'b1;
          gate_l  = 1'b1;
        end
      endcase
    end

    assign fetch_en_o[gi]      = fetch_l;
    assign clk_gate_core_o[gi] = gate_l;

    // TIMEOUT is latched at sleep entry; a sleeping core ignores later writes.
    always_ff @(posedge HCLK) begin
      if (HRESET) begin
        state_reg  <= ST_RUN;
        cnt_reg    <= '0;
        tmr_en_reg <= 1'b0;
      end else begin
        state_reg <= state_next;
        if (enter_sleep) begin
          cnt_reg    <= timeout_reg - TMR_WIDTH'(1);
          tmr_en_reg <= (timeout_reg != '0);
        end else if (in_sleep[gi] && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - TMR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sleep_unit_multi.sv
// Directed bench for sleep_unit_multi: register-map vector table plus hand-written sleep/wake sequences.
module tb_sleep_unit_multi;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [3:0]  signal_i, core_busy_i, fetch_en_o, clk_gate_core_o;

  int total = 0;
  int bad   = 0;

  sleep_unit_multi #(.APB_ADDR_WIDTH(12), .NB_CORES(4), .TMR_WIDTH(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .signal_i(signal_i), .core_busy_i(core_busy_i), .fetch_en_o(fetch_en_o),
    .clk_gate_core_o(clk_gate_core_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Called #1 after an edge; setup cycle, access cycle, write commits at the second edge.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                          output logic [31:0] rd, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #1;
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic hold_read(input logic [11:0] addr);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = addr;
  endtask

  task automatic release_bus();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cnt;
    int          slept;

    tbl[0]  = '{1'b1, 12'h000, 32'h0000_0003, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 32'h0,         32'h3, 1'b0};
    tbl[2]  = '{1'b1, 12'h010, 32'h0000_0001, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 12'h000, 32'h0,         32'h2, 1'b0};
    tbl[4]  = '{1'b1, 12'h00C, 32'h0000_0008, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 32'h0,         32'hA, 1'b0};
    tbl[6]  = '{1'b0, 12'h00C, 32'h0,         32'h0, 1'b0};
    tbl[7]  = '{1'b0, 12'h010, 32'h0,         32'h0, 1'b0};
    tbl[8]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 12'h000, 32'h0,         32'hF, 1'b0};
    tbl[10] = '{1'b1, 12'h008, 32'h1234_ABCD, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 12'h008, 32'h0,         32'h0000_ABCD, 1'b0};
    tbl[12] = '{1'b0, 12'h01C, 32'h0,         32'h0, 1'b1};
    tbl[13] = '{1'b0, 12'h018, 32'h0,         32'h0, 1'b1};
    tbl[14] = '{1'b1, 12'h004, 32'h0000_000F, 32'h0, 1'b1};
    tbl[15] = '{1'b0, 12'h004, 32'h0,         32'h0, 1'b0};
    tbl[16] = '{1'b0, 12'h014, 32'h0,         32'h0, 1'b0};
    tbl[17] = '{1'b0, 12'h100, 32'h0,         32'h0, 1'b1};
    tbl[18] = '{1'b1, 12'h000, 32'h0,         32'h0, 1'b0};
    tbl[19] = '{1'b1, 12'h008, 32'h0,         32'h0, 1'b0};
    tbl[20] = '{1'b0, 12'h008, 32'h0,         32'h0, 1'b0};

    HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    signal_i = 4'h0; core_busy_i = 4'h0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_fetch", 32'(fetch_en_o), 32'hF);
    check("rst_gate", 32'(clk_gate_core_o), 32'hF);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_slverr", 32'(PSLVERR), 32'h0);
    HRESET = 1'b0;

    // Register map with every core held awake by its signal.
    signal_i = 4'hF;
    for (int i = 0; i < 21; i++) begin
      apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
      if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
    end
    signal_i = 4'h0;

    // Cores 0 and 2 go to sleep with TIMEOUT=0.
    apb_xfer(1'b1, 12'h000, 32'h5, rd, err);
    check("t1_fetch_run", 32'(fetch_en_o), 32'hA);
    @(posedge HCLK); #1;
    check("t1_fetch_shut", 32'(fetch_en_o), 32'hA);
    check("t1_gate_shut", 32'(clk_gate_core_o), 32'hF);
    @(posedge HCLK); #1;
    check("t1_gate_sleep", 32'(clk_gate_core_o), 32'hA);
    check("t1_fetch_sleep", 32'(fetch_en_o), 32'hF);
    apb_xfer(1'b0, 12'h004, 32'h0, rd, err);
    check("t1_status", rd, 32'h5);
    apb_xfer(1'b0, 12'h000, 32'h0, rd, err);
    check("t1_ctrl_cleared", rd, 32'h0);

    // Core 1 sleeps, one-cycle signal pulse reopens its clock combinationally.
    apb_xfer(1'b1, 12'h00C, 32'h2, rd, err);
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    check("t2_gate_sleep", 32'(clk_gate_core_o), 32'h8);
    signal_i = 4'b0010;
    #1;
    check("t2_gate_wake", 32'(clk_gate_core_o), 32'hA);
    @(posedge HCLK); #1;
    signal_i = 4'h0;
    check("t2_fetch_run", 32'(fetch_en_o), 32'hF);
    apb_xfer(1'b0, 12'h004, 32'h0, rd, err);
    check("t2_status", rd, 32'h5);
    apb_xfer(1'b0, 12'h014, 32'h0, rd, err);
    check("t2_wake_cause", rd, 32'h0);

    // Timed sleep of core 3, STATUS watched every cycle through a held read.
    apb_xfer(1'b1, 12'h008, 32'd10, rd, err);
    apb_xfer(1'b1, 12'h00C, 32'h8, rd, err);
    hold_read(12'h004);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge HCLK); #1;
      if (PRDATA[3]) cnt++;
    end
    check("t3_sleep_cycles", 32'(cnt), 32'd10);
    check("t3_status_after", PRDATA, 32'h5);
    release_bus();
    apb_xfer(1'b0, 12'h014, 32'h0, rd, err);
    check("t3_wake_cause", rd, 32'h8);
    apb_xfer(1'b1, 12'h014, 32'h8, rd, err);
    apb_xfer(1'b0, 12'h014, 32'h0, rd, err);
    check("t3_wake_cause_w1c", rd, 32'h0);
    apb_xfer(1'b1, 12'h008, 32'h0, rd, err);

    // Core 0: wake it, then hold it in SHUTDOWN with busy before a signal sends it back.
    signal_i = 4'b0001;
    @(posedge HCLK); #1;
    signal_i = 4'h0;
    core_busy_i = 4'b0001;
    apb_xfer(1'b1, 12'h00C, 32'h1, rd, err);
    hold_read(12'h004);
    cnt = 0; slept = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge HCLK); #1;
      if (!fetch_en_o[0]) cnt++;
      if (PRDATA[0]) slept++;
    end
    check("t4_shutdown_cycles", 32'(cnt), 32'd5);
    signal_i = 4'b0001;
    @(posedge HCLK); #1;
    if (PRDATA[0]) slept++;
    check("t4_never_slept", 32'(slept), 32'd0);
    check("t4_fetch0", 32'(fetch_en_o[0]), 32'd1);
    apb_xfer(1'b1, 12'h010, 32'h1, rd, err);
    signal_i = 4'h0;
    core_busy_i = 4'h0;

    // CTRL_SET committing in core 1's first SLEEP cycle beats the hardware clear.
    apb_xfer(1'b1, 12'h00C, 32'h2, rd, err);
    @(posedge HCLK); #1;
    apb_xfer(1'b1, 12'h00C, 32'h2, rd, err);
    hold_read(12'h000);
    #1;
    check("t5_ctrl_set_wins", PRDATA, 32'h2);
    check("t5_core1_asleep", 32'(clk_gate_core_o[1]), 32'd0);
    release_bus();

    // Reset while cores 1 and 2 sleep and registers hold nonzero values.
    signal_i = 4'b1000;
    apb_xfer(1'b1, 12'h008, 32'd7, rd, err);
    apb_xfer(1'b1, 12'h00C, 32'h8, rd, err);
    apb_xfer(1'b0, 12'h000, 32'h0, rd, err);
    check("t6_ctrl_pre", rd, 32'h8);
    check("t6_gate_pre", 32'(clk_gate_core_o), 32'h9);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    signal_i = 4'h0;
    check("t6_fetch", 32'(fetch_en_o), 32'hF);
    check("t6_gate", 32'(clk_gate_core_o), 32'hF);
    apb_xfer(1'b0, 12'h000, 32'h0, rd, err);
    check("t6_ctrl", rd, 32'h0);
    apb_xfer(1'b0, 12'h008, 32'h0, rd, err);
    check("t6_timeout", rd, 32'h0);
    apb_xfer(1'b0, 12'h004, 32'h0, rd, err);
    check("t6_status", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sleep_unit_multi.md
Name: sleep_unit_multi

Overview:
- Multi-core, parametrised sleep controller on the APB peripheral bus.
- Holds one RUN/SHUTDOWN/SLEEP controller per core. Each one gates fetch and clock of its own core.
- Adds features the single-core controller lacks: atomic set/clear of sleep-enable bits, a timed wake-up, a wake-cause record, and an error response on unmapped or illegal accesses.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4KB slave).
- NB_CORES, 4, number of cores controlled (1..32); bit i of every per-core field/port belongs to core i.
- TMR_WIDTH, 16, wake-up timer width (1..32); TIMEOUT register bits above TMR_WIDTH-1 read 0.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset, synchronous, active-high.
- PADDR  in  APB_ADDR_WIDTH  APB address; word index PADDR[4:2].
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PRDATA  out  32  APB read data.
- PREADY  out  1  always 1.
- PSLVERR  out  1  APB error.
- signal_i  in  NB_CORES  per-core interrupt/event pending.
- core_busy_i  in  NB_CORES  per-core busy.
- fetch_en_o  out  NB_CORES  per-core fetch enable.
- clk_gate_core_o  out  NB_CORES  per-core clock enable; 0 blocks the clock.

Behaviour:
- Reset (HRESET=1 at a HCLK edge): all FSMs RUN; all registers 0; timers 0; fetch_en_o and clk_gate_core_o all 1; PRDATA 0; PSLVERR 0.
- Register map (word offsets):
  - 0x00 CTRL rw: sleep enable bits.
  - 0x04 STATUS ro: bit i=1 when FSM i is in SLEEP (live state).
  - 0x08 TIMEOUT rw: wake-up timeout; 0 = disabled.
  - 0x0C CTRL_SET wo: write-1-to-set CTRL; reads 0.
  - 0x10 CTRL_CLR wo: write-1-to-clear CTRL; reads 0.
  - 0x14 WAKE_CAUSE rw1c: bit i=1 when the last wake of core i was caused by timeout.
- CTRL bits and WAKE_CAUSE bits at NB_CORES and above read 0 and ignore writes.
- APB access phase is PSEL&PENABLE. Writes commit at the HCLK edge. PRDATA is combinational during the access phase and 0 otherwise.
- PSLVERR=1 during the access phase for offsets 0x18 and above, and for writes to STATUS. Those writes have no effect.
- Per-core FSM i (en=CTRL[i], sig=signal_i[i]):
  - RUN->SHUTDOWN: en & !sig.
  - SHUTDOWN->RUN: sig.
  - SHUTDOWN->SLEEP: !sig & !core_busy_i[i].
  - SLEEP->RUN: wake, where wake = sig | tmr_exp.
- Per-core outputs by state:
  - RUN: fetch_en=!(en & !sig), clk_gate=1.
  - SHUTDOWN: fetch_en=0, clk_gate=1.
  - SLEEP: fetch_en=1, clk_gate=wake. This is combinational: the clock reopens in the same cycle as the wake.
- Timer, on the SHUTDOWN->SLEEP edge:
  - cnt_i <= TIMEOUT-1 and tmr_en_i <= (TIMEOUT!=0). TIMEOUT is sampled at entry only; later writes do not affect a sleeping core.
  - In SLEEP, cnt_i decrements while nonzero.
  - tmr_exp = SLEEP & tmr_en_i & cnt_i==0. The core therefore spends exactly TIMEOUT cycles in SLEEP when no signal arrives.
- WAKE_CAUSE, on SLEEP->RUN: bit i <= tmr_exp & !sig. A signal wins on a tie and clears the bit.
- CTRL update order within one cycle:
  1. HW clear of bit i when FSM i is in SLEEP.
  2. Then APB write to CTRL, CTRL_SET or CTRL_CLR. The APB write wins, so a set during SLEEP re-arms: after wake the core goes RUN then straight to SHUTDOWN.
- WAKE_CAUSE collision: a HW set in the same cycle as a W1C on the same bit keeps the bit set.
- A reset mid-sleep returns to RUN with clocks enabled, regardless of the FSM state.
- FSMs are fully independent. An illegal state encoding recovers to RUN.

Test Plan:
- NB_CORES=4, TIMEOUT=0; write CTRL=0x5, signal_i=0, core_busy_i=0 -> fetch_en_o=0xA in the next cycle; SHUTDOWN then SLEEP for cores 0 and 2; STATUS=0x5; CTRL reads 0x0; clk_gate_core_o=0xA.
- Core 1 in SLEEP; pulse signal_i[1] for 1 cycle -> clk_gate_core_o[1]=1 in the same cycle; RUN next cycle; WAKE_CAUSE[1]=0.
- TIMEOUT=10, sleep core 3 with no signal -> exactly 10 cycles with STATUS[3]=1; then RUN; WAKE_CAUSE=0x8; write WAKE_CAUSE=0x8 -> reads 0.
- Core 0 in SHUTDOWN with core_busy_i[0]=1 held 5 cycles, then signal_i[0]=1 -> back to RUN, never reaches SLEEP; fetch_en_o[0]=1.
- CTRL=0x3; write CTRL_CLR=0x1 -> 0x2; write CTRL_SET=0x8 -> 0xA; write CTRL_SET in the same cycle core 1 enters SLEEP -> bit 1 stays 1.
- Read offset 0x1C -> PSLVERR=1, PRDATA=0; write STATUS -> PSLVERR=1, STATUS unchanged; assert HRESET while cores sleep -> next cycle fetch_en_o and clk_gate_core_o all 1, all registers 0.
